// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared bus types, IO window constants and region decode helper
package mem_responder_pkg;
  typedef logic [7:0] byte_bus_t;
  typedef logic [31:0] mem_addr_bus_t;
  localparam logic [1:0] IoSelDef = 2'b11;
  localparam logic [2:0] IoDataOff = 3'd0;
  localparam logic [2:0] IoDoneOff = 3'd4;
  function automatic logic in_io(mem_addr_bus_t a, logic [1:0] sel);
    return a[17:16] == sel;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU beat bus plus host-side TX/RX byte streams of the memory responder
interface mem_responder_if;
  import mem_responder_pkg::*;
  logic ram_rw;
  mem_addr_bus_t ram_addr;
  byte_bus_t ram_w_data;
  byte_bus_t ram_r_data;
  logic io_full;
  logic io_tx_valid;
  byte_bus_t io_tx_data;
  logic io_tx_ready;
  logic io_rx_valid;
  byte_bus_t io_rx_data;
  logic io_rx_ready;
  logic io_overflow;
  logic sim_done;
  modport master (
    output ram_rw, ram_addr, ram_w_data, io_tx_ready, io_rx_valid, io_rx_data,
    input ram_r_data, io_full, io_tx_valid, io_tx_data, io_rx_ready, io_overflow, sim_done
  );
  modport slave (
    input ram_rw, ram_addr, ram_w_data, io_tx_ready, io_rx_valid, io_rx_data,
    output ram_r_data, io_full, io_tx_valid, io_tx_data, io_rx_ready, io_overflow, sim_done
  );
endinterface

// File: rtl/mem_responder_byte_fifo.sv
// byte_fifo: power-of-two byte FIFO; a pop frees the slot for a same-cycle push, a pop on empty is ignored
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [7:0]   din,
  output logic [7:0]   head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign head = mem[rd_ptr];
  // effective pop/push after empty/full qualification
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
  end
  // storage, no reset
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at DEPTH
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM plus IO window (TX FIFO, optional RX FIFO under MEM_RESPONDER_RX_FIFO_EN)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter logic [1:0] IO_SEL = IoSelDef,
  parameter int FIFO_DEPTH = 8
) (
  input logic clock,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FullMark = CW'(FIFO_DEPTH - 2);
  byte_bus_t mem [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] idx;
  logic [2:0] off;
  logic is_io, tx_push, tx_pop, tx_full, tx_empty, rx_pop, rx_empty;
  logic [CW-1:0] tx_count;
  byte_bus_t rx_head, rd_next;
  logic unused_bits;
  // beat decode and read-data selection
  always_comb begin
    is_io = in_io(bus.ram_addr, IO_SEL);
    idx = bus.ram_addr[RAM_ADDR_W-1:0];
    off = bus.ram_addr[2:0];
    tx_push = is_io && bus.ram_rw && off == IoDataOff;
    tx_pop = !tx_empty && bus.io_tx_ready;
    rx_pop = is_io && !bus.ram_rw && off == IoDataOff && !rx_empty;
    rd_next = !is_io ? mem[idx] : rx_pop ? rx_head : '0;
  end
  assign bus.io_tx_valid = !tx_empty;
  assign bus.io_full = tx_count > FullMark;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
    .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus.ram_w_data),
    .head(bus.io_tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
`ifdef MEM_RESPONDER_RX_FIFO_EN
  logic rx_full;
  logic [CW-1:0] rx_count;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
    .clock(clock), .reset(reset), .push(bus.io_rx_valid && !rx_full), .pop(rx_pop),
    .din(bus.io_rx_data), .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  assign bus.io_rx_ready = !rx_full;
  assign unused_bits = ^{bus.ram_addr[31:18], rx_count};
`else
  assign rx_empty = 1'b1;
  assign rx_head = '0;
  assign bus.io_rx_ready = 1'b0;
  assign unused_bits = ^{bus.ram_addr[31:18], bus.io_rx_valid, bus.io_rx_data};
`endif
  // RAM array write port
  always_ff @(posedge clock)
    if (!is_io && bus.ram_rw) mem[idx] <= bus.ram_w_data;
  // registered read data and sticky status flags
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus.ram_r_data <= '0;
      bus.io_overflow <= 1'b0;
      bus.sim_done <= 1'b0;
    end else begin
      if (!bus.ram_rw) bus.ram_r_data <= rd_next;
      if (tx_push && tx_full && !tx_pop) bus.io_overflow <= 1'b1;
      if (is_io && bus.ram_rw && off == IoDoneOff) bus.sim_done <= 1'b1;
    end
endmodule
